// File: rtl/shuffle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shuffle_sequencer
// Purpose  : Builds a random deal order (a permutation of 0..N_CARDS-1) for
//            the memory game. An LFSR is stepped between draws. Each draw
//            takes LFSR % N_CARDS as a candidate. A candidate that is already
//            used is replaced by linear probing to the next free index. The
//            result is stored in a table that has a registered read port.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            start_i             - begin a new shuffle (accepted in IDLE only)
//            seed_load_i, seed_i - load the LFSR seed (accepted in IDLE only)
//            busy_o              - shuffle in progress
//            done_o              - one-cycle pulse when the table is complete
//            table_valid_o       - table holds a complete permutation
//            rd_addr_i/rd_data_o - table read port, 1-cycle latency
// Revision : 1.0 - initial release
// ============================================================================
module shuffle_sequencer #(
    parameter int N_CARDS        = 20,
    parameter int LFSR_W         = 8,
    parameter int STEPS_PER_DRAW = 8,
    parameter int IDX_W          = $clog2(N_CARDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              seed_load_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              table_valid_o,
    input  logic [IDX_W-1:0]  rd_addr_i,
    output logic [IDX_W-1:0]  rd_data_o
);

    localparam int STEP_W = (STEPS_PER_DRAW > 1) ? $clog2(STEPS_PER_DRAW) : 1;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_step  = 3'd1;
    localparam logic [2:0] c_st_check = 3'd2;
    localparam logic [2:0] c_st_probe = 3'd3;
    localparam logic [2:0] c_st_write = 3'd4;
    localparam logic [2:0] c_st_done  = 3'd5;

    localparam logic [IDX_W-1:0]  c_last_idx  = IDX_W'(N_CARDS - 1);
    localparam logic [STEP_W-1:0] c_step_last = STEP_W'(STEPS_PER_DRAW - 1);
    localparam logic [IDX_W:0]    c_n_cards   = (IDX_W+1)'(N_CARDS);

    logic [2:0]         r_state;
    logic [LFSR_W-1:0]  r_lfsr;
    logic [STEP_W-1:0]  r_step_cnt;
    logic [IDX_W-1:0]   r_cand;
    logic [IDX_W-1:0]   r_slot;
    logic [N_CARDS-1:0] r_used;
    logic [IDX_W-1:0]   r_table [N_CARDS];
    logic               r_valid;
    logic [IDX_W-1:0]   r_rd_data;

    logic [LFSR_W-1:0]  w_lfsr_next;
    logic [LFSR_W-1:0]  w_seed_val;
    logic [IDX_W-1:0]   w_draw;
    logic [IDX_W-1:0]   w_probe_next;

    assign w_lfsr_next  = {r_lfsr[LFSR_W-2:0],
                           r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[4]};
    // An all-zero LFSR would never leave zero, so a zero seed becomes all-ones.
    assign w_seed_val   = (seed_i == '0) ? '1 : seed_i;
    assign w_draw       = IDX_W'(r_lfsr % LFSR_W'(N_CARDS));
    assign w_probe_next = (r_cand == c_last_idx) ? '0 : r_cand + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_lfsr     <= '1;
            r_step_cnt <= '0;
            r_cand     <= '0;
            r_slot     <= '0;
            r_used     <= '0;
            r_valid    <= 1'b0;
            for (int i = 0; i < N_CARDS; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            case (r_state)
                c_st_idle: begin
                    // The seed and the start are accepted in the same cycle.
                    // The new shuffle then steps from the freshly loaded seed.
                    if (seed_load_i) begin
                        r_lfsr <= w_seed_val;
                    end
                    if (start_i) begin
                        r_used     <= '0;
                        r_slot     <= '0;
                        r_step_cnt <= '0;
                        r_valid    <= 1'b0;
                        r_state    <= c_st_step;
                    end
                end
                c_st_step: begin
                    r_lfsr <= w_lfsr_next;
                    if (r_step_cnt == c_step_last) begin
                        r_step_cnt <= '0;
                        r_state    <= c_st_check;
                    end else begin
                        r_step_cnt <= r_step_cnt + 1'b1;
                    end
                end
                c_st_check: begin
                    r_cand  <= w_draw;
                    r_state <= r_used[w_draw] ? c_st_probe : c_st_write;
                end
                c_st_probe: begin
                    // At least one index is free, so the probe always ends.
                    r_cand <= w_probe_next;
                    if (!r_used[w_probe_next]) begin
                        r_state <= c_st_write;
                    end
                end
                c_st_write: begin
                    r_table[r_slot] <= r_cand;
                    r_used[r_cand]  <= 1'b1;
                    if (r_slot == c_last_idx) begin
                        r_valid <= 1'b1;
                        r_state <= c_st_done;
                    end else begin
                        r_slot  <= r_slot + 1'b1;
                        r_state <= c_st_step;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // The read port is free-running. During a shuffle it returns partial contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if ({1'b0, rd_addr_i} < c_n_cards) begin
            r_rd_data <= r_table[rd_addr_i];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign busy_o        = (r_state == c_st_step)  || (r_state == c_st_check) ||
                           (r_state == c_st_probe) || (r_state == c_st_write);
    assign done_o        = (r_state == c_st_done);
    assign table_valid_o = r_valid;
    assign rd_data_o     = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_shuffle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shuffle_sequencer
// Purpose  : Self-checking bench for shuffle_sequencer. A behavioural model
//            computes each complete deal and its cycle count from the
//            draw/probe rules. The outputs are compared on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shuffle_sequencer;

    localparam int N = 20;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b0;
    logic       start_i     = 1'b0;
    logic       seed_load_i = 1'b0;
    logic [7:0] seed_i      = 8'd0;
    logic [4:0] rd_addr_i   = 5'd0;
    logic       busy_o;
    logic       done_o;
    logic       table_valid_o;
    logic [4:0] rd_data_o;

    shuffle_sequencer #(
        .N_CARDS        (20),
        .LFSR_W         (8),
        .STEPS_PER_DRAW (8),
        .IDX_W          (5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .seed_load_i   (seed_load_i),
        .seed_i        (seed_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .table_valid_o (table_valid_o),
        .rd_addr_i     (rd_addr_i),
        .rd_data_o     (rd_data_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] m_lfsr     = 8'hFF;
    bit         m_active   = 1'b0;
    bit         m_valid    = 1'b0;
    bit         m_rd_ok    = 1'b1;
    bit         rd_ok_next = 1'b1;
    int         m_cyc      = 0;
    int         m_lat      = 0;
    int         m_start10  = 0;
    int         m_c        = 0;
    int         m_p        = 0;
    bit [N-1:0] m_used     = '0;
    logic [4:0] m_rd       = 5'd0;
    logic [4:0] m_table [N] = '{default: 5'd0};
    logic [4:0] m_new   [N] = '{default: 5'd0};

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[0] ^ x[2] ^ x[3] ^ x[4]};
    endfunction

    // m_cyc counts clock edges since the start was accepted.
    // The DONE cycle is reached when m_cyc == m_lat.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr   = 8'hFF;
            m_active = 1'b0;
            m_valid  = 1'b0;
            m_cyc    = 0;
            m_rd     = 5'd0;
            m_rd_ok  = 1'b1;
            for (int i = 0; i < N; i++) m_table[i] = 5'd0;
        end else begin
            rd_ok_next = !m_active || (m_cyc == m_lat);
            m_rd = (rd_addr_i < N) ? m_table[rd_addr_i] : 5'd0;
            if (m_active) begin
                if (m_cyc == m_lat) begin
                    m_active = 1'b0;
                end else begin
                    m_cyc++;
                    if (m_cyc == m_lat) begin
                        for (int i = 0; i < N; i++) m_table[i] = m_new[i];
                        m_valid = 1'b1;
                    end
                end
            end else begin
                if (seed_load_i) m_lfsr = (seed_i == 8'd0) ? 8'hFF : seed_i;
                if (start_i) begin
                    m_used = '0;
                    m_lat  = 0;
                    for (int s = 0; s < N; s++) begin
                        if (s == 10) m_start10 = m_lat;
                        for (int k = 0; k < 8; k++) m_lfsr = lfsr_next(m_lfsr);
                        m_c = int'(m_lfsr) % N;
                        m_p = 0;
                        while (m_used[m_c]) begin
                            m_c = (m_c + 1) % N;
                            m_p++;
                        end
                        m_used[m_c] = 1'b1;
                        m_new[s]    = 5'(m_c);
                        m_lat       = m_lat + 10 + m_p;
                    end
                    m_active = 1'b1;
                    m_cyc    = 0;
                    m_valid  = 1'b0;
                end
            end
            m_rd_ok = rd_ok_next;
        end
    end

    // ---------------- checking / driving ----------------
    int n_chk  = 0;
    int n_fail = 0;
    bit manual = 1'b0;
    bit noisy  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("busy",  int'(busy_o),        int'(m_active && (m_cyc < m_lat)));
        chk("done",  int'(done_o),        int'(m_active && (m_cyc == m_lat)));
        chk("valid", int'(table_valid_o), int'(m_valid));
        if (m_rd_ok) chk("rd_data", int'(rd_data_o), int'(m_rd));
        if (!manual) rd_addr_i = 5'($urandom_range(0, 31));
        if (noisy && m_active && (m_cyc < m_lat)) begin
            start_i     = 1'($urandom_range(0, 1));
            seed_load_i = 1'($urandom_range(0, 1));
            seed_i      = 8'($urandom);
        end else begin
            start_i     = 1'b0;
            seed_load_i = 1'b0;
        end
    endtask

    task automatic wait_done(output int ndone);
        int budget;
        int after;
        bit seen;
        budget = 0;
        after  = 0;
        seen   = 1'b0;
        ndone  = 0;
        while (budget < 700 && after < 3) begin
            tick();
            budget++;
            if (done_o === 1'b1) begin
                ndone++;
                seen = 1'b1;
            end
            if (seen) after++;
        end
        chk("done_timeout", int'(seen), 1);
    endtask

    task automatic run(input bit load, input logic [7:0] seed, input bit nz);
        int nd;
        seed_load_i = load;
        seed_i      = seed;
        start_i     = 1'b1;
        noisy       = nz;
        tick();
        chk("lat_bound", int'(m_lat <= 580), 1);
        wait_done(nd);
        noisy = 1'b0;
        chk("done_pulses", nd, 1);
        chk("valid_after", int'(table_valid_o), 1);
    endtask

    task automatic readback(input bit want_perm);
        bit [N-1:0] seen;
        seen   = '0;
        manual = 1'b1;
        for (int a = 0; a < N; a++) begin
            rd_addr_i = 5'(a);
            tick();
            chk("readback", int'(rd_data_o), int'(m_table[a]));
            if (rd_data_o < N) seen[rd_data_o] = 1'b1;
        end
        manual = 1'b0;
        if (want_perm) chk("perm", int'(&seen), 1);
    endtask

    initial begin
        logic [4:0] tbl_ff [N];
        logic [4:0] tbl_5a [N];
        logic [7:0] lf;
        bit [N-1:0] mseen;
        int         ndiff;
        int         b;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        readback(1'b0);

        // Pin the model LFSR against the known FF sequence
        lf = 8'hFF;
        lf = lfsr_next(lf);
        chk("lfsr_step1", int'(lf), 8'hFE);
        for (int k = 1; k < 8; k++) lf = lfsr_next(lf);
        chk("lfsr_step8", int'(lf), 8'h44);

        // Default shuffle from the reset seed
        run(1'b0, 8'd0, 1'b0);
        chk("tbl0_literal", int'(m_table[0]), 8);
        mseen = '0;
        for (int i = 0; i < N; i++) mseen[m_table[i]] = 1'b1;
        chk("model_perm", int'(&mseen), 1);
        readback(1'b1);
        for (int i = 0; i < N; i++) tbl_ff[i] = m_table[i];

        // Read-port literals
        manual = 1'b1;
        rd_addr_i = 5'd0;
        tick();
        chk("rd0_literal", int'(rd_data_o), 8);
        rd_addr_i = 5'd25;
        tick();
        chk("rd25_zero", int'(rd_data_o), 0);
        manual = 1'b0;

        // A zero seed behaves like FF
        run(1'b1, 8'd0, 1'b0);
        ndiff = 0;
        for (int i = 0; i < N; i++) if (m_table[i] != tbl_ff[i]) ndiff++;
        chk("seed0_eq_ff", ndiff, 0);
        readback(1'b1);

        // Seed 5A twice gives the same deal, and it differs from FF
        run(1'b1, 8'h5A, 1'b0);
        readback(1'b1);
        for (int i = 0; i < N; i++) tbl_5a[i] = m_table[i];
        run(1'b1, 8'h5A, 1'b0);
        readback(1'b1);
        ndiff = 0;
        for (int i = 0; i < N; i++) if (m_table[i] != tbl_5a[i]) ndiff++;
        chk("seed5a_repeat", ndiff, 0);
        ndiff = 0;
        for (int i = 0; i < N; i++) if (tbl_5a[i] != tbl_ff[i]) ndiff++;
        chk("seed5a_ne_ff", int'(ndiff > 0), 1);

        // Start/seed pulses during a shuffle must be ignored
        run(1'b1, 8'd0, 1'b1);
        ndiff = 0;
        for (int i = 0; i < N; i++) if (m_table[i] != tbl_ff[i]) ndiff++;
        chk("noisy_eq_ff", ndiff, 0);
        readback(1'b1);

        // Asynchronous reset while slot 10 is being drawn
        seed_load_i = 1'b1;
        seed_i      = 8'd0;
        start_i     = 1'b1;
        tick();
        b = 0;
        while (m_cyc < m_start10 + 3 && b < 700) begin
            tick();
            b++;
        end
        chk("reach_slot10", int'(b < 700), 1);
        chk("busy_pre_rst", int'(busy_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",  int'(busy_o),        0);
        chk("arst_done",  int'(done_o),        0);
        chk("arst_valid", int'(table_valid_o), 0);
        chk("arst_rd",    int'(rd_data_o),     0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        readback(1'b0);
        run(1'b0, 8'd0, 1'b0);
        ndiff = 0;
        for (int i = 0; i < N; i++) if (m_table[i] != tbl_ff[i]) ndiff++;
        chk("post_rst_eq_ff", ndiff, 0);

        // Random seeds with random interference
        for (int r = 0; r < 4; r++) begin
            run(1'b1, 8'($urandom), 1'b1);
            readback(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shuffle_sequencer.md
Name: shuffle_sequencer

Overview:
Clocked controller that builds a 20-card deal order for the memory game at run time. It steps an 8-bit LFSR, draws candidate card indices, rejects indices already drawn, and fills a permutation table. The table is exposed to the game FSM through a registered read port. A start/busy/done handshake lets the top-level FSM reshuffle the table between rounds.

Parameters:
N_CARDS, 20, number of card slots; the table holds a permutation of 0..N_CARDS-1
LFSR_W, 8, LFSR width
STEPS_PER_DRAW, 8, LFSR shifts between consecutive draws (must be at least 1)
IDX_W, $clog2(N_CARDS) (5), width of card index and address

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
start_i  in  1  request a new shuffle; sampled only in IDLE
seed_load_i  in  1  load seed_i into the LFSR; sampled only in IDLE
seed_i  in  LFSR_W  seed value
busy_o  out  1  high from the cycle after start is accepted until done_o
done_o  out  1  one-cycle pulse when the table is complete
table_valid_o  out  1  table holds a complete permutation
rd_addr_i  in  IDX_W  read slot address
rd_data_o  out  IDX_W  card index stored at rd_addr_i, registered

Behaviour:
- Reset (async, rst_n=0):
  - LFSR=8'hFF; state=IDLE; busy_o=0; done_o=0; table_valid_o=0.
  - used mask=0; slot counter=0; all table entries=0; rd_data_o=0.
- LFSR shift: fb = L[0]^L[2]^L[3]^L[4]; L <= {L[6:0],fb}.
- Seed load: a seed of 0 loads 8'hFF, so the LFSR cannot lock up.
- FSM states:
  - IDLE: if seed_load_i, the LFSR loads the seed. If start_i, clear the used mask, clear the slot counter, drop table_valid_o, and go to STEP. If both are asserted in the same cycle, the seed loads first and the new shuffle uses the new seed.
  - STEP: shift the LFSR once per cycle for STEPS_PER_DRAW cycles, then go to CHECK.
  - CHECK: cand = LFSR % N_CARDS (unsigned, IDX_W bits). If used[cand]=0, go to WRITE; otherwise go to PROBE.
  - PROBE: each cycle set cand = (cand==N_CARDS-1) ? 0 : cand+1. Go to WRITE when used[cand]=0. At most N_CARDS-1 probe cycles are needed.
  - WRITE: table[slot]=cand; used[cand]=1. If slot==N_CARDS-1, go to DONE; otherwise slot++ and go to STEP.
  - DONE: done_o=1 for this cycle only; busy_o=0; table_valid_o=1; go to IDLE.
- busy_o is 1 in STEP, CHECK, PROBE and WRITE.
- Ignored inputs: start_i and seed_load_i are ignored outside IDLE. There is no queueing.
- The LFSR holds its value in every state except STEP and seed load.
- Read port:
  - rd_data_o <= table[rd_addr_i] on every clock; latency is 1 cycle.
  - rd_addr_i >= N_CARDS returns 0.
  - Reads during a shuffle return current contents, which may be partial; consumers must gate reads with table_valid_o.
- Worst-case shuffle latency: N_CARDS*(STEPS_PER_DRAW+2+N_CARDS-1) cycles, plus 1 for DONE.
- Reset asserted mid-shuffle: everything aborts to reset values; the table is invalid until a new start.
- Identical seed followed by start always yields an identical table (deterministic).

Test Plan:
- Reset -> busy_o=0, done_o=0, table_valid_o=0, rd_data_o=0 for every address.
- No seed load, pulse start_i -> LFSR goes FF,FE,FD,FA,F4,E8,D1,A2,44; table[0]=8 (0x44 % 20). done_o pulses once within 581 cycles. The 20 entries are a permutation of 0..19 with no duplicates. table_valid_o=1 after done.
- seed_load_i with seed_i=0, then start -> table identical to the previous scenario. seed_i=8'h5A, then start twice -> both tables identical, and different from the FF-seed table.
- Assert start_i and seed_load_i mid-shuffle -> no restart and no LFSR reload; the table matches an uninterrupted run; exactly one done_o pulse.
- Drop rst_n while slot=10 -> asynchronous return to reset values; a following start produces the FF-seed table.
- rd_addr_i=25 -> rd_data_o=0 next cycle. rd_addr_i=0 after the default shuffle -> rd_data_o=8 exactly one cycle later.
